mcdt_dist: RTL and testbench



---
 rtl/mcdt_dist_pkg.sv | 23 ++
 rtl/mcdt_dist_fifo.sv | 71 +++++++
 rtl/mcdt_dist.sv | 102 ++++++++++
 tb/tb_mcdt_dist.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcdt_dist_pkg.sv
// mcdt_dist_pkg
// Shared constants for the mcdt receive-side distributor: default stream
// width and FIFO depth, derived pointer/count widths, channel count and the
// reserved (illegal) channel id.
package mcdt_dist_pkg;

  localparam int DIST_DW    = 32;
  localparam int DIST_DEPTH = 16;
  localparam int NUM_CH     = 3;

  typedef logic [1:0] ch_id_t;
  localparam ch_id_t ID_BAD = 2'b11;

  // Pointer width for a power-of-two depth.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DIST_PTR_W = ptr_width(DIST_DEPTH);
  // One extra bit so the count can represent a completely full FIFO.
  localparam int DIST_CNT_W = DIST_PTR_W + 1;

endpackage

// File: rtl/mcdt_dist_fifo.sv
// dist_fifo
// Single-clock synchronous FIFO used once per distributor channel.
// Ports:
//   clk_i, rstn_i : clock, async active-low reset (clears pointers/count)
//   push_i        : write request; accepted when not full or popped same cycle
//   wdata_i       : write data
//   pop_i         : read request; ignored while empty
//   rdata_o       : head entry, forced to 0 while empty
//   valid_o       : FIFO non-empty
//   margin_o      : free entries (DEPTH - count)
//   full_o        : count == DEPTH
module dist_fifo
  import mcdt_dist_pkg::*;
#(
  parameter  int DW    = DIST_DW,
  parameter  int DEPTH = DIST_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic             pop_i,
  output logic [DW-1:0]    rdata_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] margin_o,
  output logic             full_o
);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign valid_o  = (count != '0);
  assign full_o   = (count == CNT_W'(DEPTH));
  assign margin_o = CNT_W'(DEPTH) - count;

  // A pop frees a slot at the same edge, so a full FIFO can still take a push.
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  // Masking with the registered valid keeps the head at 0 while empty,
  // including straight out of reset.
  assign rdata_o = valid_o ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mcdt_dist.sv
// mcdt_dist
// Receive-side distributor: steers merged (data, valid, id) beats into three
// per-channel FIFOs drained by valid/ready consumers. The input stream cannot
// be stalled, so beats to a full channel or to the reserved id are dropped
// and reported through sticky flags.
// Ports:
//   clk_i, rstn_i          : clock, async active-low reset
//   mcdt_data_i/val_i/id_i : incoming beat
//   chN_data_o/valid_o     : head of FIFO N and its non-empty flag
//   chN_ready_i            : consumer N takes the head this cycle
//   chN_margin_o           : free entries in FIFO N
//   ovf_o                  : sticky per-channel overflow
//   bad_id_o               : sticky illegal-id flag
//   err_clr_i              : synchronous clear of ovf_o / bad_id_o
module mcdt_dist
  import mcdt_dist_pkg::*;
#(
  parameter  int DW    = DIST_DW,
  parameter  int DEPTH = DIST_DEPTH,
  localparam int CNT_W = ptr_width(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [DW-1:0]    mcdt_data_i,
  input  logic             mcdt_val_i,
  input  logic [1:0]       mcdt_id_i,
  output logic [DW-1:0]    ch0_data_o,
  output logic             ch0_valid_o,
  input  logic             ch0_ready_i,
  output logic [CNT_W-1:0] ch0_margin_o,
  output logic [DW-1:0]    ch1_data_o,
  output logic             ch1_valid_o,
  input  logic             ch1_ready_i,
  output logic [CNT_W-1:0] ch1_margin_o,
  output logic [DW-1:0]    ch2_data_o,
  output logic             ch2_valid_o,
  input  logic             ch2_ready_i,
  output logic [CNT_W-1:0] ch2_margin_o,
  output logic [2:0]       ovf_o,
  output logic             bad_id_o,
  input  logic             err_clr_i
);

  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] valid;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push_sel;
  logic [NUM_CH-1:0] ovf_set;
  logic [DW-1:0]     data   [NUM_CH];
  logic [CNT_W-1:0]  margin [NUM_CH];
  logic              bad_set;

  assign ready = {ch2_ready_i, ch1_ready_i, ch0_ready_i};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign push_sel[n] = mcdt_val_i && (mcdt_id_i == 2'(n));
    // Dropped only when full and the consumer is not freeing a slot now.
    assign ovf_set[n]  = push_sel[n] && full[n] && !(valid[n] && ready[n]);

    dist_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .push_i   (push_sel[n]),
      .wdata_i  (mcdt_data_i),
      .pop_i    (ready[n]),
      .rdata_o  (data[n]),
      .valid_o  (valid[n]),
      .margin_o (margin[n]),
      .full_o   (full[n])
    );
  end

  assign bad_set = mcdt_val_i && (mcdt_id_i == ID_BAD);

  // Sticky error flags; an error arriving with the clear still lands.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_o    <= '0;
      bad_id_o <= 1'b0;
    end else if (err_clr_i) begin
      ovf_o    <= ovf_set;
      bad_id_o <= bad_set;
    end else begin
      ovf_o    <= ovf_o | ovf_set;
      bad_id_o <= bad_id_o | bad_set;
    end
  end

  assign ch0_data_o   = data[0];
  assign ch0_valid_o  = valid[0];
  assign ch0_margin_o = margin[0];
  assign ch1_data_o   = data[1];
  assign ch1_valid_o  = valid[1];
  assign ch1_margin_o = margin[1];
  assign ch2_data_o   = data[2];
  assign ch2_valid_o  = valid[2];
  assign ch2_margin_o = margin[2];

endmodule

// File: tb/tb_mcdt_dist.sv
module tb_mcdt_dist;
  import mcdt_dist_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic [DW-1:0] mcdt_data_i;
  logic          mcdt_val_i;
  logic [1:0]    mcdt_id_i;
  logic [DW-1:0] ch0_data_o, ch1_data_o, ch2_data_o;
  logic          ch0_valid_o, ch1_valid_o, ch2_valid_o;
  logic          ch0_ready_i, ch1_ready_i, ch2_ready_i;
  logic [4:0]    ch0_margin_o, ch1_margin_o, ch2_margin_o;
  logic [2:0]    ovf_o;
  logic          bad_id_o;
  logic          err_clr_i;

  always #5 clk = ~clk;

  mcdt_dist dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .mcdt_data_i  (mcdt_data_i),
    .mcdt_val_i   (mcdt_val_i),
    .mcdt_id_i    (mcdt_id_i),
    .ch0_data_o   (ch0_data_o),
    .ch0_valid_o  (ch0_valid_o),
    .ch0_ready_i  (ch0_ready_i),
    .ch0_margin_o (ch0_margin_o),
    .ch1_data_o   (ch1_data_o),
    .ch1_valid_o  (ch1_valid_o),
    .ch1_ready_i  (ch1_ready_i),
    .ch1_margin_o (ch1_margin_o),
    .ch2_data_o   (ch2_data_o),
    .ch2_valid_o  (ch2_valid_o),
    .ch2_ready_i  (ch2_ready_i),
    .ch2_margin_o (ch2_margin_o),
    .ovf_o        (ovf_o),
    .bad_id_o     (bad_id_o),
    .err_clr_i    (err_clr_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus the two sticky flags.
  logic [DW-1:0] q0[$], q1[$], q2[$];
  logic [2:0]    m_ovf;
  logic          m_bad;

  function automatic int qsize(input int c);
    case (c)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qhead(input int c);
    if (qsize(c) == 0) return '0;
    case (c)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int c);
    case (c)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int c, input logic [DW-1:0] d);
    case (c)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    m_ovf = '0;
    m_bad = 1'b0;
  endtask

  // Applies one clock edge worth of behaviour using the inputs presented.
  task automatic model_step();
    logic [2:0] rdy;
    logic [2:0] novf;
    logic       nbad;
    rdy  = {ch2_ready_i, ch1_ready_i, ch0_ready_i};
    novf = '0;
    nbad = mcdt_val_i && (mcdt_id_i == 2'd3);
    for (int c = 0; c < 3; c++) begin
      if (qsize(c) > 0 && rdy[c]) qpop(c);
      if (mcdt_val_i && mcdt_id_i == 2'(c)) begin
        if (qsize(c) < DEPTH) qpush(c, mcdt_data_i);
        else                  novf[c] = 1'b1;
      end
    end
    if (err_clr_i) begin
      m_ovf = novf;
      m_bad = nbad;
    end else begin
      m_ovf = m_ovf | novf;
      m_bad = m_bad | nbad;
    end
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_v0"}, 32'(ch0_valid_o),  32'(qsize(0) > 0));
    check({tag, "_v1"}, 32'(ch1_valid_o),  32'(qsize(1) > 0));
    check({tag, "_v2"}, 32'(ch2_valid_o),  32'(qsize(2) > 0));
    check({tag, "_d0"}, ch0_data_o,        qhead(0));
    check({tag, "_d1"}, ch1_data_o,        qhead(1));
    check({tag, "_d2"}, ch2_data_o,        qhead(2));
    check({tag, "_m0"}, 32'(ch0_margin_o), 32'(DEPTH - qsize(0)));
    check({tag, "_m1"}, 32'(ch1_margin_o), 32'(DEPTH - qsize(1)));
    check({tag, "_m2"}, 32'(ch2_margin_o), 32'(DEPTH - qsize(2)));
    check({tag, "_ovf"}, 32'(ovf_o),       32'(m_ovf));
    check({tag, "_bad"}, 32'(bad_id_o),    32'(m_bad));
  endtask

  // One clock: model follows the DUT edge, outputs sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    mcdt_val_i  = 1'b0;
    mcdt_id_i   = 2'd0;
    mcdt_data_i = '0;
    err_clr_i   = 1'b0;
  endtask

  logic [DW-1:0] vals [17];
  logic [DW-1:0] nb;

  initial begin
    rstn_i = 1'b0;
    ch0_ready_i = 1'b0; ch1_ready_i = 1'b0; ch2_ready_i = 1'b0;
    idle_inputs();
    model_reset();

    // Reset state
    #2;
    check_all("reset");
    check("reset_m0_const", 32'(ch0_margin_o), 32'd16);
    @(negedge clk);
    rstn_i = 1'b1;

    // Single beat to channel 1
    mcdt_val_i = 1'b1; mcdt_id_i = 2'd1; mcdt_data_i = 32'hA5A5_0001;
    cycle("t1");
    idle_inputs();
    check("t1_valid1", 32'(ch1_valid_o),  32'd1);
    check("t1_data1",  ch1_data_o,        32'hA5A5_0001);
    check("t1_m1",     32'(ch1_margin_o), 32'd15);
    check("t1_m0",     32'(ch0_margin_o), 32'd16);
    ch1_ready_i = 1'b1;
    cycle("t1_drain");
    ch1_ready_i = 1'b0;

    // Fill channel 0, then overflow with a 17th beat
    for (int i = 0; i < 17; i++) begin
      vals[i] = $urandom;
      mcdt_val_i = 1'b1; mcdt_id_i = 2'd0; mcdt_data_i = vals[i];
      cycle("t2_fill");
    end
    idle_inputs();
    check("t2_m0_full", 32'(ch0_margin_o), 32'd0);
    check("t2_ovf",     32'(ovf_o),        32'b001);
    ch0_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_order", ch0_data_o, vals[i]);
      cycle("t2_drain");
    end
    ch0_ready_i = 1'b0;
    check("t2_empty", 32'(ch0_valid_o), 32'd0);

    // Channel 2 full, push with simultaneous pop
    for (int i = 0; i < 16; i++) begin
      mcdt_val_i = 1'b1; mcdt_id_i = 2'd2; mcdt_data_i = $urandom;
      cycle("t3_fill");
    end
    nb = 32'hC0DE_0002;
    mcdt_data_i = nb; ch2_ready_i = 1'b1;
    cycle("t3_pushpop");
    idle_inputs();
    ch2_ready_i = 1'b0;
    check("t3_no_ovf2", 32'(ovf_o[2]),     32'd0);
    check("t3_m2",      32'(ch2_margin_o), 32'd0);
    ch2_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t3_last", ch2_data_o, nb);
      cycle("t3_drain");
    end
    ch2_ready_i = 1'b0;

    // Illegal id, then clear; then clear racing a new error
    mcdt_val_i = 1'b1; mcdt_id_i = 2'd3; mcdt_data_i = 32'hDEAD_BEEF;
    cycle("t4_bad");
    idle_inputs();
    check("t4_bad_set", 32'(bad_id_o),     32'd1);
    check("t4_m1",      32'(ch1_margin_o), 32'd16);
    err_clr_i = 1'b1;
    cycle("t4_clr");
    err_clr_i = 1'b0;
    check("t4_bad_clr", 32'(bad_id_o), 32'd0);
    check("t4_ovf_clr", 32'(ovf_o),    32'd0);
    mcdt_val_i = 1'b1; mcdt_id_i = 2'd3; err_clr_i = 1'b1;
    cycle("t4_race");
    idle_inputs();
    check("t4_race_bad", 32'(bad_id_o), 32'd1);
    err_clr_i = 1'b1;
    cycle("t4_clr2");
    err_clr_i = 1'b0;

    // Interleaved traffic at full rate with all consumers ready
    ch0_ready_i = 1'b1; ch1_ready_i = 1'b1; ch2_ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      mcdt_val_i = 1'b1; mcdt_id_i = 2'(i % 3); mcdt_data_i = $urandom;
      cycle("t5");
    end
    idle_inputs();
    cycle("t5_tail");
    check("t5_m0",  32'(ch0_margin_o), 32'd16);
    check("t5_m2",  32'(ch2_margin_o), 32'd16);
    check("t5_err", 32'({ovf_o, bad_id_o}), 32'd0);

    // Random traffic including illegal ids, backpressure and clears
    for (int i = 0; i < 400; i++) begin
      mcdt_val_i  = ($urandom_range(0, 3) != 0);
      mcdt_id_i   = 2'($urandom_range(0, 3));
      mcdt_data_i = $urandom;
      ch0_ready_i = ($urandom_range(0, 2) == 0);
      ch1_ready_i = ($urandom_range(0, 1) == 0);
      ch2_ready_i = ($urandom_range(0, 3) == 0);
      err_clr_i   = ($urandom_range(0, 15) == 0);
      cycle("rnd");
    end
    idle_inputs();

    // Reset with all FIFOs partly full
    ch0_ready_i = 1'b0; ch1_ready_i = 1'b0; ch2_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mcdt_val_i = 1'b1; mcdt_id_i = 2'(i % 3); mcdt_data_i = $urandom;
      cycle("t6_fill");
    end
    idle_inputs();
    #2;
    rstn_i = 1'b0;
    #1;
    model_reset();
    check_all("t6_rst");
    check("t6_v1", 32'(ch1_valid_o),  32'd0);
    check("t6_m2", 32'(ch2_margin_o), 32'd16);
    @(negedge clk);
    rstn_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mcdt_val_i = 1'b1; mcdt_id_i = 2'(i % 3); mcdt_data_i = 32'h5000_0000 + 32'(i);
      cycle("t6_post");
    end
    idle_inputs();
    check("t6_post_d0", ch0_data_o, 32'h5000_0000);
    ch0_ready_i = 1'b1; ch1_ready_i = 1'b1; ch2_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
